sensor_frame_tx: RTL and testbench
==================================

SENSOR_FRAME_TX -- requirements
Module: sensor_frame_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CLK_FREQ SHALL be: default 100_000_000; input clock frequency in Hz.
REQ-003 Parameter BAUD_RATE SHALL be: default 115_200; serial bit rate.
REQ-004 Parameter FRAME_HDR SHALL be: default 8'hA5; first byte of every frame.
REQ-005 Port clk SHALL be: input, 1 bit; sole clock, rising edge.
REQ-006 Port rst_n SHALL be: input, 1 bit; synchronous active-low reset.
REQ-007 Port sample_valid SHALL be: input, 1 bit; sample offered.
REQ-008 Port sample_data SHALL be: input, 16 bits; sensor sample.
REQ-009 Port sample_ready SHALL be: output, 1 bit; block can accept a sample.
REQ-010 Port uart_tx SHALL be: output, 1 bit; serial line, idle high.
REQ-011 Port frame_busy SHALL be: output, 1 bit; frame in progress.
REQ-012 Port frame_done SHALL be: output, 1 bit; one-cycle pulse at frame end.
REQ-013 Port seq_num SHALL be: output, 8 bits; sequence number of the next frame.

Function
REQ-014 TPB SHALL equal CLK_FREQ/BAUD_RATE (integer division); every line bit SHALL last exactly TPB cycles.
REQ-015 A sample SHALL be accepted on a rising edge where sample_valid=1 and sample_ready=1; sample_data SHALL be captured on that edge.
REQ-016 sample_ready SHALL be 1 only in IDLE; sample_valid while not ready SHALL be ignored, with no queueing.
REQ-017 Frame SHALL be 5 bytes in order: FRAME_HDR, seq_num, sample[15:8], sample[7:0], CSUM.
REQ-018 CSUM SHALL equal (seq + sample[15:8] + sample[7:0]) mod 256, with the header excluded.
REQ-019 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
REQ-020 Bytes SHALL be back-to-back with no idle gap, giving a line-active time of exactly 50*TPB cycles per frame.
REQ-021 uart_tx SHALL drive the header start bit from the cycle after acceptance.
REQ-022 Top FSM states: IDLE, HDR, SEQ, DHI, DLO, CSUM, each byte state advancing on the serializer byte-complete pulse; CSUM SHALL return to IDLE.
REQ-023 frame_done SHALL pulse for the one cycle entering IDLE from CSUM, and sample_ready SHALL be 1 in that same cycle.
REQ-024 seq_num SHALL increment by 1 on frame_done, wrapping 8'hFF to 8'h00.
REQ-025 frame_busy SHALL be 1 in every state other than IDLE.
REQ-026 uart_tx SHALL be 1 whenever the block is in IDLE.
REQ-027 sample_data changes after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-028 On rst_n=0 at a clock edge, the block SHALL set: state IDLE, uart_tx=1, sample_ready=1, frame_busy=0, frame_done=0, seq_num=0, all counters 0.
REQ-029 A reset mid-frame SHALL abort the frame without emitting a frame_done pulse, with uart_tx high on the following cycle.
REQ-030 A sample offered during reset SHALL NOT be accepted.

Structure
REQ-031 The shared package sensor_uart_pkg SHALL hold the FSM state typedef, the FRAME_HDR default and the frame length constant (5).
REQ-032 One sub-module SHALL exist: byte_serializer, with inputs load and byte and outputs line and byte_done, owning the tick and bit counters.
REQ-033 Counter widths SHALL be derived from TPB via $clog2.

Verification
Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (TPB=10).
REQ-034 Accept sample 16'h1234 after reset -> line bytes A5 00 12 34 46 with 500 active cycles, frame_done pulses once, then seq_num=1.
REQ-035 Second frame with 16'hFFFF -> line bytes A5 01 FF FF FF (checksum wrap), then seq_num=2.
REQ-036 Hold sample_valid high during a frame while changing sample_data -> no second acceptance mid-frame, frame carries the captured value, and the next frame starts the cycle after frame_done.
REQ-037 Send 256 frames -> 256th carries seq 8'hFF, and seq_num then reads 8'h00.
REQ-038 Assert rst_n=0 during the DHI byte -> uart_tx=1 next cycle, no frame_done, seq_num=0, sample_ready=1.
REQ-039 Loop uart_tx to a reference receiver model -> every received byte matches, with no framing (stop-bit) errors.

Source files
------------

// File: rtl/sensor_uart_pkg.sv
// Shared types and constants for the sensor frame UART transmitter.
// Holds the frame FSM state type, default header byte and frame geometry.
package sensor_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        DHI,
        DLO,
        CSUM
    } state_t;

    localparam logic [7:0] FRAME_HDR_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 5;
    // start + 8 data + stop
    localparam int         LINE_BITS     = 10;

    // Header is deliberately excluded from the checksum.
    function automatic logic [7:0] csum8(input logic [7:0] seq, input logic [15:0] smp);
        return seq + smp[15:8] + smp[7:0];
    endfunction

endpackage

// File: rtl/sensor_frame_tx_if.sv
// Sample handshake between a sensor front-end (master) and the frame transmitter (slave).
interface sensor_frame_tx_if;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        sample_ready;

    modport master (output sample_valid, output sample_data, input sample_ready);
    modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/byte_serializer.sv
// 8N1 byte serializer: a load restarts it with a new byte; o_byte_done flags the last
// cycle of the stop bit so the next byte can be loaded with no idle gap.
module byte_serializer
    import sensor_uart_pkg::*;
#(
    parameter int TPB = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_line,
    output logic       o_byte_done
);

    localparam int TW = (TPB > 1) ? $clog2(TPB) : 1;
    localparam int BW = $clog2(LINE_BITS);

    logic [TW-1:0] r_tick;
    logic [BW-1:0] r_bit;
    logic [8:0]    r_shift;
    logic          r_busy;
    logic          r_line;

    logic w_tick_last;
    logic w_bit_last;

    assign w_tick_last = (r_tick == TW'(TPB - 1));
    assign w_bit_last  = (r_bit == BW'(LINE_BITS - 1));
    assign o_byte_done = r_busy && w_tick_last && w_bit_last;
    assign o_line      = r_line;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_busy  <= 1'b0;
            r_line  <= 1'b1;
        end else if (i_load) begin
            // Start bit goes out on the line right after the load edge.
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= {1'b1, i_byte};
            r_busy  <= 1'b1;
            r_line  <= 1'b0;
        end else if (r_busy) begin
            if (w_tick_last) begin
                r_tick <= '0;
                if (w_bit_last) begin
                    r_busy <= 1'b0;
                    r_line <= 1'b1;
                end else begin
                    r_bit   <= r_bit + BW'(1);
                    r_line  <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_tick <= r_tick + TW'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_frame_tx.sv
// Frames a 16-bit sensor sample as HDR, SEQ, DHI, DLO, CSUM and sends it over a UART line.
// Bytes are chained on the serializer's done pulse so the frame is one unbroken burst.
module sensor_frame_tx
    import sensor_uart_pkg::*;
#(
    parameter int         CLK_FREQ  = 100_000_000,
    parameter int         BAUD_RATE = 115_200,
    parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sensor_frame_tx_if.slave        s_if,
    output logic                    uart_tx,
    output logic                    frame_busy,
    output logic                    frame_done,
    output logic [7:0]              seq_num
);

    localparam int TPB = CLK_FREQ / BAUD_RATE;

    state_t      r_state;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_seq;
    logic [15:0] r_sample;

    logic        w_accept;
    logic        w_byte_done;
    logic        w_load;
    logic [7:0]  w_byte;

    assign w_accept = r_ready && s_if.sample_valid;
    // The next byte is loaded on the same edge the current stop bit ends.
    assign w_load   = w_accept || (w_byte_done && (r_state != CSUM));

    always_comb begin
        w_byte = FRAME_HDR;
        case (r_state)
            IDLE:    w_byte = FRAME_HDR;
            HDR:     w_byte = r_seq;
            SEQ:     w_byte = r_sample[15:8];
            DHI:     w_byte = r_sample[7:0];
            DLO:     w_byte = csum8(r_seq, r_sample);
            default: w_byte = FRAME_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_seq    <= 8'h00;
            r_sample <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_sample <= s_if.sample_data;
                    r_state  <= HDR;
                    r_ready  <= 1'b0;
                    r_busy   <= 1'b1;
                end
                HDR:  if (w_byte_done) r_state <= SEQ;
                SEQ:  if (w_byte_done) r_state <= DHI;
                DHI:  if (w_byte_done) r_state <= DLO;
                DLO:  if (w_byte_done) r_state <= CSUM;
                CSUM: if (w_byte_done) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_seq   <= r_seq + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    byte_serializer #(
        .TPB (TPB)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_byte      (w_byte),
        .o_line      (uart_tx),
        .o_byte_done (w_byte_done)
    );

    assign s_if.sample_ready = r_ready;
    assign frame_busy        = r_busy;
    assign frame_done        = r_done;
    assign seq_num           = r_seq;

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Directed bench: main DUT at TPB=10 with a reference 8N1 receiver; a second DUT at TPB=2
// covers the sequence-number wrap in a short run.
module tb_sensor_frame_tx;

    localparam int TPB = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sensor_frame_tx_if bus();
    sensor_frame_tx_if bus2();

    logic       tx, busy, done;
    logic [7:0] seq;
    logic       tx2, busy2, done2;
    logic [7:0] seq2;

    sensor_frame_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (bus),
        .uart_tx    (tx),
        .frame_busy (busy),
        .frame_done (done),
        .seq_num    (seq)
    );

    sensor_frame_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(500_000)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (bus2),
        .uart_tx    (tx2),
        .frame_busy (busy2),
        .frame_done (done2),
        .seq_num    (seq2)
    );

    int n_tot  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int busy_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        busy_cnt <= busy_cnt + int'(busy);
        done_cnt <= done_cnt + int'(done);
    end

    // Reference receiver: samples mid-bit, offset counted from the first low sample.
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_ferr = 0;
    logic [7:0] rx_q[$];
    int         rd_ptr = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on  <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on  <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == TPB / 2 && tx !== 1'b0) rx_ferr <= rx_ferr + 1;
            if (rx_cnt > TPB && rx_cnt < 9 * TPB && rx_cnt % TPB == TPB / 2)
                rx_sh <= {tx, rx_sh[7:1]};
            if (rx_cnt == 9 * TPB + TPB / 2) begin
                if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
                rx_q.push_back(rx_sh);
                rx_on <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int which, input int bound);
        int k;
        logic seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < bound) begin
            @(negedge clk);
            k++;
            seen = (which == 1) ? (done === 1'b1) : (done2 === 1'b1);
        end
        chk($sformatf("done_seen_%0d", which), 32'(seen), 32'd1);
        #1;
    endtask

    task automatic accept1(input logic [15:0] d);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.sample_data  = ~d;
    endtask

    task automatic accept2;
        @(negedge clk);
        bus2.sample_valid = 1'b1;
        @(negedge clk);
        bus2.sample_valid = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [39:0] exp);
        logic [7:0] got;
        chk({tag, "_nbytes"}, 32'(rx_q.size() - rd_ptr), 32'd5);
        for (int i = 0; i < 5; i++) begin
            got = (rd_ptr + i < rx_q.size()) ? rx_q[rd_ptr + i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), 32'(got), 32'(exp[39 - 8 * i -: 8]));
        end
        rd_ptr = rx_q.size();
    endtask

    initial begin
        int b0, d0, nd;
        logic [7:0] sb;

        bus.sample_valid  = 1'b1;
        bus.sample_data   = 16'h1234;
        bus2.sample_valid = 1'b0;
        bus2.sample_data  = 16'h0000;

        // Reset state, with a sample offered throughout reset
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx),               32'd1);
        chk("rst_ready", 32'(bus.sample_ready), 32'd1);
        chk("rst_busy",  32'(busy),             32'd0);
        chk("rst_done",  32'(done),             32'd0);
        chk("rst_seq",   32'(seq),              32'd0);
        bus.sample_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_noacc_busy", 32'(busy), 32'd0);
        chk("rst_noacc_tx",   32'(tx),   32'd1);
        #1;

        // Frame 1: 0x1234, seq 0 -> A5 00 12 34 46
        b0 = busy_cnt; d0 = done_cnt;
        accept1(16'h1234);
        chk("f1_start_tx",  32'(tx),               32'd0);
        chk("f1_busy",      32'(busy),             32'd1);
        chk("f1_ready",     32'(bus.sample_ready), 32'd0);
        wait_done(1, 700);
        chk("f1_ndone",     32'(done_cnt - d0),    32'd1);
        chk("f1_active",    32'(busy_cnt - b0),    32'd500);
        chk("f1_seq",       32'(seq),              32'd1);
        chk("f1_done_rdy",  32'(bus.sample_ready), 32'd1);
        chk("f1_done_tx",   32'(tx),               32'd1);
        chk_frame("f1", 40'hA5_00_12_34_46);

        // Frame 2: 0xFFFF, seq 1 -> checksum wraps to FF
        b0 = busy_cnt; d0 = done_cnt;
        accept1(16'hFFFF);
        wait_done(1, 700);
        chk("f2_ndone",  32'(done_cnt - d0), 32'd1);
        chk("f2_active", 32'(busy_cnt - b0), 32'd500);
        chk("f2_seq",    32'(seq),           32'd2);
        chk_frame("f2", 40'hA5_01_FF_FF_FF);

        // Valid held high across a frame while data changes
        b0 = busy_cnt; d0 = done_cnt;
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'hBEEF;
        @(negedge clk);
        bus.sample_data  = 16'h1111;
        chk("hv_start_tx", 32'(tx), 32'd0);
        wait_done(1, 700);
        chk("hv_ndone",  32'(done_cnt - d0), 32'd1);
        chk("hv_active", 32'(busy_cnt - b0), 32'd500);
        chk_frame("hv", 40'hA5_02_BE_EF_AF);
        @(negedge clk);
        chk("hv_restart_tx",   32'(tx),   32'd0);
        chk("hv_restart_busy", 32'(busy), 32'd1);
        bus.sample_valid = 1'b0;
        wait_done(1, 700);
        chk("hv2_seq", 32'(seq), 32'd4);
        chk_frame("hv2", 40'hA5_03_11_11_25);
        chk("rx_framing_errors", 32'(rx_ferr), 32'd0);

        // Reset in the middle of the DHI byte
        accept1(16'hABCD);
        repeat (250) @(negedge clk);
        #1;
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_tx",    32'(tx),               32'd1);
        chk("mr_done",  32'(done),             32'd0);
        chk("mr_seq",   32'(seq),              32'd0);
        chk("mr_ready", 32'(bus.sample_ready), 32'd1);
        chk("mr_busy",  32'(busy),             32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("mr_ndone", 32'(done_cnt - d0), 32'd0);
        chk("mr_idle_tx", 32'(tx), 32'd1);
        rd_ptr = rx_q.size();

        // Sequence wrap on the fast instance: 255 frames, then inspect the 256th seq byte
        nd = 0;
        for (int f = 0; f < 255; f++) begin
            accept2();
            wait_done(2, 300);
            nd++;
        end
        chk("wrap_frames",  32'(nd),   32'd255);
        chk("wrap_seq_pre", 32'(seq2), 32'hFF);
        accept2();
        sb = 8'h00;
        for (int n = 1; n <= 38; n++) begin
            @(negedge clk);
            if (n == 20) chk("wrap_seq_start", 32'(tx2), 32'd0);
            if (n >= 22 && n <= 36 && (n % 2) == 0) sb[(n - 22) / 2] = tx2;
            if (n == 38) chk("wrap_seq_stop", 32'(tx2), 32'd1);
        end
        chk("wrap_seq_byte", 32'(sb), 32'hFF);
        wait_done(2, 300);
        chk("wrap_seq_post", 32'(seq2), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
